// File: rtl/or1200_seqdiv_if.sv
// or1200_seqdiv_if: EX-stage divider handshake and operand/result bundle.
// master = pipeline side (drives operands/start), slave = divider.
interface or1200_seqdiv_if #(
   parameter int width = 32
);
   logic             ex_freeze;
   logic             div_start;
   logic             div_signed;
   logic [width-1:0] operand_a;
   logic [width-1:0] operand_b;
   logic [width-1:0] result;
   logic             div_done;
   logic             div_ovf;
   logic             div_stall;

   modport master (
      output ex_freeze, div_start, div_signed, operand_a, operand_b,
      input  result, div_done, div_ovf, div_stall
   );

   modport slave (
      input  ex_freeze, div_start, div_signed, operand_a, operand_b,
      output result, div_done, div_ovf, div_stall
   );
endinterface

// File: rtl/or1200_seqdiv.sv
// or1200_seqdiv: restoring sequential divider, one quotient bit per cycle.
// Optional feature macro: OR1200_SEQDIV_SIGNED_EN (signed l.div support:
// abs-value capture, sign fixup of the quotient, MIN/-1 overflow flag).
// Without it every divide is unsigned and div_ovf flags divide-by-zero only.
module or1200_seqdiv #(
   parameter int width = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   or1200_seqdiv_if.slave       bus
);
   localparam int CW = (width > 1) ? $clog2(width) : 1;

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t           state_q, state_d;
   logic [width-1:0] dvd_q, dvd_d;      // dividend, shifted out MSB first
   logic [width-1:0] dvs_q, dvs_d;      // divisor magnitude
   logic [width:0]   rem_q, rem_d;      // partial remainder
   logic [width-1:0] quot_q, quot_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             neg_q, neg_d;      // quotient must be negated on exit
   logic             ovf_q, ovf_d;
   logic [width-1:0] result_q, result_d;

   // Iteration datapath: shift in next dividend bit, trial-subtract divisor.
   logic [width:0]   rem_shift, rem_sub;
   logic             q_bit;
   logic [width-1:0] quot_next, quot_fix;
   assign rem_shift = {rem_q[width-1:0], dvd_q[width-1]};
   assign rem_sub   = rem_shift - {1'b0, dvs_q};
   assign q_bit     = (rem_shift >= {1'b0, dvs_q});
   assign quot_next = {quot_q[width-2:0], q_bit};

   logic [width-1:0] a_cap, b_cap;
   logic             neg_cap, min_m1;
`ifdef OR1200_SEQDIV_SIGNED_EN
   logic a_neg, b_neg;
   assign a_neg    = bus.div_signed & bus.operand_a[width-1];
   assign b_neg    = bus.div_signed & bus.operand_b[width-1];
   assign a_cap    = a_neg ? (~bus.operand_a + 1'b1) : bus.operand_a;
   assign b_cap    = b_neg ? (~bus.operand_b + 1'b1) : bus.operand_b;
   assign neg_cap  = a_neg ^ b_neg;
   assign min_m1   = bus.div_signed
                   & (bus.operand_a == {1'b1, {(width-1){1'b0}}})
                   & (&bus.operand_b);
   assign quot_fix = neg_q ? (~quot_next + 1'b1) : quot_next;
   logic unused_rem;
   assign unused_rem = rem_q[width];
`else
   assign a_cap    = bus.operand_a;
   assign b_cap    = bus.operand_b;
   assign neg_cap  = 1'b0;
   assign min_m1   = 1'b0;
   assign quot_fix = quot_next;
   logic unused_bits;
   assign unused_bits = bus.div_signed ^ neg_q ^ rem_q[width];
`endif

   // Next-state and datapath update for the IDLE/BUSY/DONE controller.
   always_comb begin
      state_d  = state_q;
      dvd_d    = dvd_q;
      dvs_d    = dvs_q;
      rem_d    = rem_q;
      quot_d   = quot_q;
      cnt_d    = cnt_q;
      neg_d    = neg_q;
      ovf_d    = ovf_q;
      result_d = result_q;
      case (state_q)
         IDLE: begin
            if (bus.div_start) begin
               dvd_d  = a_cap;
               dvs_d  = b_cap;
               rem_d  = '0;
               quot_d = '0;
               cnt_d  = CW'(width - 1);
               neg_d  = neg_cap;
               if (bus.operand_b == '0) begin
                  // Divide-by-zero finishes at once with a zero quotient.
                  state_d  = DONE;
                  result_d = '0;
                  ovf_d    = 1'b1;
               end else begin
                  state_d = BUSY;
                  ovf_d   = min_m1;
               end
            end
         end
         BUSY: begin
            rem_d  = q_bit ? rem_sub : rem_shift;
            dvd_d  = {dvd_q[width-2:0], 1'b0};
            quot_d = quot_next;
            if (cnt_q == '0) begin
               state_d  = DONE;
               result_d = quot_fix;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         DONE: begin
            if (!bus.ex_freeze) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         dvd_q    <= '0;
         dvs_q    <= '0;
         rem_q    <= '0;
         quot_q   <= '0;
         cnt_q    <= '0;
         neg_q    <= 1'b0;
         ovf_q    <= 1'b0;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         dvd_q    <= dvd_d;
         dvs_q    <= dvs_d;
         rem_q    <= rem_d;
         quot_q   <= quot_d;
         cnt_q    <= cnt_d;
         neg_q    <= neg_d;
         ovf_q    <= ovf_d;
         result_q <= result_d;
      end
   end

   assign bus.result    = result_q;
   assign bus.div_done  = (state_q == DONE);
   assign bus.div_ovf   = (state_q == DONE) & ovf_q;
   assign bus.div_stall = ((state_q == IDLE) & bus.div_start) | (state_q == BUSY);
endmodule
